vram_arbiter: RTL and testbench

- Shares the single-port 64 KB video/system RAM between the display fetch path and the Z80 bus.
- Video fetch has strict priority and bounded latency (2–3 clocks), so the pixel shifter never misses a byte.
- The CPU is stalled with cpu_wait_n until its access completes.
- Sits between the video block, the CPU bus glue and the RAM macro (registered read, 1-cycle latency).

---
 rtl/vram_arbiter_pkg.sv | 16 +
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_arbiter_wbuf.sv | 45 ++++
 rtl/vram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared definitions for the VRAM arbiter.
// Holds the default RAM geometry and the arbiter state encoding.
package vram_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VID_ISSUE = 3'd1,
    ST_VID_DATA  = 3'd2,
    ST_CPU_ISSUE = 3'd3,
    ST_CPU_DATA  = 3'd4
  } state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video fetch, CPU bus and RAM port signals of the arbiter.
// slave = arbiter view, master = surrounding system (video, CPU glue, RAM).
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait_n;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ack, cpu_wait_n,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ack, cpu_wait_n,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/vram_arbiter_wbuf.sv
// vram_arbiter_wbuf: one-entry posted CPU write buffer.
// Only compiled when VRAM_WBUF_EN is defined; the default build has no buffer.
`ifdef VRAM_WBUF_EN
module vram_arbiter_wbuf
  import vram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_drain,
  output logic          o_full,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata
);

  logic          r_full;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  // Capture a posted write; the full flag drops when the arbiter issues it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (i_drain) begin
      r_full  <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule
`endif

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video/system RAM between the display
// fetch path (strict priority, 2-3 clock latency) and the Z80 bus (stalled
// through cpu_wait_n). Optional posted-write buffer: define VRAM_WBUF_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant_pt;
  logic          w_vid_go;
  logic [AW-1:0] w_vid_addr;
  logic          w_cpu_busy;
  logic          w_cpu_go;
  logic          w_cpu_sel;
  logic          w_cpu_done;
  logic          w_ack_nxt;

  logic          r_vid_pend;
  logic [AW-1:0] r_vid_addr;
  logic          r_vid_overrun;
  logic          r_vid_valid;
  logic [DW-1:0] r_vid_data;

  logic          r_cpu_ack;
  logic          r_cpu_armed;
  logic          r_cpu_blk;
  logic [DW-1:0] r_cpu_rdata;

  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_wdata;

`ifdef VRAM_WBUF_EN
  logic          w_buf_full;
  logic [AW-1:0] w_buf_addr;
  logic [DW-1:0] w_buf_wdata;
  logic          w_drain;
  logic          w_post;
  logic          r_drain_acc;

  vram_arbiter_wbuf #(
    .AW(AW),
    .DW(DW)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_post),
    .i_addr  (bus.cpu_addr),
    .i_wdata (bus.cpu_wdata),
    .i_drain (w_drain),
    .o_full  (w_buf_full),
    .o_addr  (w_buf_addr),
    .o_wdata (w_buf_wdata)
  );
`endif

  // Grant decision (video > buffered write > CPU) and next-state logic
  always_comb begin
    w_grant_pt  = (r_state == ST_IDLE) || (r_state == ST_VID_DATA) ||
                  (r_state == ST_CPU_DATA);
    w_vid_go    = bus.vid_req || r_vid_pend;
    w_vid_addr  = bus.vid_req ? bus.vid_addr : r_vid_addr;
`ifdef VRAM_WBUF_EN
    // A drain occupies the CPU states but is not the CPU's own access
    w_cpu_busy  = ((r_state == ST_CPU_ISSUE) || (r_state == ST_CPU_DATA)) && !r_drain_acc;
    w_drain     = w_grant_pt && !w_vid_go && w_buf_full;
    w_cpu_go    = bus.cpu_req && !bus.cpu_we && !r_cpu_blk && !w_cpu_busy && !w_buf_full;
    w_post      = bus.cpu_req && bus.cpu_we && r_cpu_armed && !r_cpu_blk && !w_buf_full;
    w_cpu_sel   = w_drain || w_cpu_go;
    w_cpu_done  = (r_state == ST_CPU_DATA) && !r_drain_acc;
    w_ack_nxt   = w_cpu_done || w_post;
`else
    w_cpu_busy  = (r_state == ST_CPU_ISSUE) || (r_state == ST_CPU_DATA);
    w_cpu_go    = bus.cpu_req && !r_cpu_blk && !w_cpu_busy;
    w_cpu_sel   = w_cpu_go;
    w_cpu_done  = (r_state == ST_CPU_DATA);
    w_ack_nxt   = w_cpu_done;
`endif
    w_state_nxt = r_state;
    case (r_state)
      ST_VID_ISSUE: w_state_nxt = ST_VID_DATA;
      ST_CPU_ISSUE: w_state_nxt = ST_CPU_DATA;
      default: begin
        if (w_vid_go)       w_state_nxt = ST_VID_ISSUE;
        else if (w_cpu_sel) w_state_nxt = ST_CPU_ISSUE;
        else                w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Hold a fetch that arrives during an ISSUE cycle; a second one is an overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vid_pend    <= 1'b0;
      r_vid_addr    <= '0;
      r_vid_overrun <= 1'b0;
    end else begin
      if (bus.vid_req && r_vid_pend) r_vid_overrun <= 1'b1;
      if (w_grant_pt) begin
        r_vid_pend <= 1'b0;
      end else if (bus.vid_req) begin
        r_vid_pend <= 1'b1;
        r_vid_addr <= bus.vid_addr;
      end
    end
  end

  // Registered RAM port; write strobe lasts only the CPU_ISSUE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= 1'b0;
      if (w_grant_pt) begin
        if (w_vid_go) begin
          r_ram_addr <= w_vid_addr;
`ifdef VRAM_WBUF_EN
        end else if (w_drain) begin
          r_ram_addr  <= w_buf_addr;
          r_ram_wdata <= w_buf_wdata;
          r_ram_we    <= 1'b1;
`endif
        end else if (w_cpu_go) begin
          r_ram_addr  <= bus.cpu_addr;
          r_ram_wdata <= bus.cpu_wdata;
          r_ram_we    <= bus.cpu_we;
        end
      end
    end
  end

`ifdef VRAM_WBUF_EN
  // Remember whether the access in the CPU states is a buffer drain (no ack)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_drain_acc <= 1'b0;
    else if (w_grant_pt) r_drain_acc <= w_drain;
  end
`endif

  // Return read data and one-cycle completion pulses on leaving the DATA states
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vid_valid <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_vid_valid <= (r_state == ST_VID_DATA);
      if (r_state == ST_VID_DATA) r_vid_data <= bus.ram_rdata;
      r_cpu_ack <= w_ack_nxt;
      if (w_cpu_done) r_cpu_rdata <= bus.ram_rdata;
    end
  end

  // CPU arming: a held request is served once; re-arm needs req seen low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_armed <= 1'b0;
      r_cpu_blk   <= 1'b0;
    end else if (w_ack_nxt) begin
      r_cpu_armed <= 1'b0;
      r_cpu_blk   <= 1'b1;
    end else begin
      r_cpu_armed <= bus.cpu_req && !r_cpu_blk;
      if (!bus.cpu_req) r_cpu_blk <= 1'b0;
    end
  end

  assign bus.vid_data    = r_vid_data;
  assign bus.vid_valid   = r_vid_valid;
  assign bus.vid_overrun = r_vid_overrun;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_wait_n  = !(bus.cpu_req && r_cpu_armed && !r_cpu_ack);
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_we      = r_ram_we;
  assign bus.ram_wdata   = r_ram_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed-vector bench for vram_arbiter with a registered
// 1-cycle-latency RAM model. Covers the default build; a VRAM_WBUF_EN build
// swaps the write sequence for the posted-write sequence.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   acks;
  int   wes;

  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(16), .DW(8)) bus ();

  vram_arbiter #(.AW(16), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: registered read, write on ram_we, a few preloaded bytes
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (reset) begin
      mem[16'h1234] <= 8'hA5;
      mem[16'h2000] <= 8'h3C;
      mem[16'hC000] <= 8'h00;
      mem[16'h0042] <= 8'h42;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = 16'h0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_wdata = 8'h0;
    tick();
    tick();
    chk("rst_ram_we",    32'(bus.ram_we), 0);
    chk("rst_ram_addr",  32'(bus.ram_addr), 0);
    chk("rst_vid_valid", 32'(bus.vid_valid), 0);
    chk("rst_vid_data",  32'(bus.vid_data), 0);
    chk("rst_cpu_ack",   32'(bus.cpu_ack), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_overrun",   32'(bus.vid_overrun), 0);
    chk("rst_wait_n",    32'(bus.cpu_wait_n), 1);
    reset = 1'b0;
    tick();

    // Video fetch alone
    bus.vid_addr = 16'h1234;
    bus.vid_req  = 1'b1;
    tick();
    bus.vid_req = 1'b0;
    chk("vid_addr_e0",  32'(bus.ram_addr), 'h1234);
    chk("vid_we_e0",    32'(bus.ram_we), 0);
    chk("vid_valid_e0", 32'(bus.vid_valid), 0);
    tick();
    chk("vid_we_e1",    32'(bus.ram_we), 0);
    chk("vid_valid_e1", 32'(bus.vid_valid), 0);
    tick();
    chk("vid_valid_e2", 32'(bus.vid_valid), 1);
    chk("vid_data_e2",  32'(bus.vid_data), 'hA5);
    chk("vid_we_e2",    32'(bus.ram_we), 0);
    tick();
    chk("vid_valid_pulse", 32'(bus.vid_valid), 0);

    // CPU write 0x5A to 0xC000
    bus.cpu_addr  = 16'hC000;
    bus.cpu_wdata = 8'h5A;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    #1;
    chk("wr_waitn_pre", 32'(bus.cpu_wait_n), 1);
`ifndef VRAM_WBUF_EN
    tick();
    chk("wr_we_a0",    32'(bus.ram_we), 1);
    chk("wr_addr_a0",  32'(bus.ram_addr), 'hC000);
    chk("wr_wdata_a0", 32'(bus.ram_wdata), 'h5A);
    chk("wr_waitn_a0", 32'(bus.cpu_wait_n), 0);
    chk("wr_ack_a0",   32'(bus.cpu_ack), 0);
    tick();
    chk("wr_we_a1",    32'(bus.ram_we), 0);
    chk("wr_waitn_a1", 32'(bus.cpu_wait_n), 0);
    chk("wr_ack_a1",   32'(bus.cpu_ack), 0);
    tick();
    chk("wr_ack_a2",   32'(bus.cpu_ack), 1);
    chk("wr_waitn_a2", 32'(bus.cpu_wait_n), 1);
    chk("wr_we_a2",    32'(bus.ram_we), 0);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    chk("wr_ack_pulse", 32'(bus.cpu_ack), 0);
`else
    tick();
    chk("wb_we_a0",    32'(bus.ram_we), 0);
    chk("wb_waitn_a0", 32'(bus.cpu_wait_n), 0);
    chk("wb_ack_a0",   32'(bus.cpu_ack), 0);
    tick();
    chk("wb_ack_a1",   32'(bus.cpu_ack), 1);
    chk("wb_waitn_a1", 32'(bus.cpu_wait_n), 1);
    chk("wb_we_a1",    32'(bus.ram_we), 0);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    chk("wb_drain_we",    32'(bus.ram_we), 1);
    chk("wb_drain_addr",  32'(bus.ram_addr), 'hC000);
    chk("wb_drain_wdata", 32'(bus.ram_wdata), 'h5A);
    bus.cpu_req = 1'b1;
    tick();
    chk("wb_rd_we_off", 32'(bus.ram_we), 0);
    chk("wb_rd_stall",  32'(bus.cpu_wait_n), 0);
    tick();
    chk("wb_rd_noack4", 32'(bus.cpu_ack), 0);
    tick();
    chk("wb_rd_noack5", 32'(bus.cpu_ack), 0);
    tick();
    chk("wb_rd_ack",   32'(bus.cpu_ack), 1);
    chk("wb_rd_rdata", 32'(bus.cpu_rdata), 'h5A);
    bus.cpu_req = 1'b0;
    tick();
`endif

    // CPU read back from 0xC000
    bus.cpu_addr = 16'hC000;
    bus.cpu_req  = 1'b1;
    tick();
    chk("rd_addr_r0", 32'(bus.ram_addr), 'hC000);
    chk("rd_we_r0",   32'(bus.ram_we), 0);
    chk("rd_ack_r0",  32'(bus.cpu_ack), 0);
    tick();
    chk("rd_ack_r1",  32'(bus.cpu_ack), 0);
    tick();
    chk("rd_ack_r2",  32'(bus.cpu_ack), 1);
    chk("rd_rdata",   32'(bus.cpu_rdata), 'h5A);
    bus.cpu_req = 1'b0;
    tick();

    // Held request: one access only, even when the address changes mid-hold
    bus.cpu_addr = 16'h1234;
    bus.cpu_req  = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(bus.cpu_ack);
    end
    bus.cpu_addr = 16'h0042;
    for (int i = 0; i < 10; i++) begin
      tick();
      acks += int'(bus.cpu_ack);
    end
    chk("held_acks",   32'(acks), 1);
    chk("held_rdata",  32'(bus.cpu_rdata), 'hA5);
    chk("held_addr",   32'(bus.ram_addr), 'h1234);
    chk("held_waitn",  32'(bus.cpu_wait_n), 1);
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1;
    tick();
    chk("rearm_addr", 32'(bus.ram_addr), 'h0042);
    tick();
    tick();
    chk("rearm_ack",   32'(bus.cpu_ack), 1);
    chk("rearm_rdata", 32'(bus.cpu_rdata), 'h42);
    bus.cpu_req = 1'b0;
    tick();

    // Video request one cycle after a CPU grant: worst-case latency
    bus.cpu_addr = 16'hC000;
    bus.cpu_req  = 1'b1;
    tick();
    bus.vid_addr = 16'h1234;
    bus.vid_req  = 1'b1;
    tick();
    bus.vid_req = 1'b0;
    chk("colA_addr_hold", 32'(bus.ram_addr), 'hC000);
    tick();
    chk("colA_cpu_ack",   32'(bus.cpu_ack), 1);
    chk("colA_cpu_rdata", 32'(bus.cpu_rdata), 'h5A);
    chk("colA_vid_addr",  32'(bus.ram_addr), 'h1234);
    bus.cpu_req = 1'b0;
    tick();
    chk("colA_valid_e2", 32'(bus.vid_valid), 0);
    tick();
    chk("colA_valid_e3", 32'(bus.vid_valid), 1);
    chk("colA_data_e3",  32'(bus.vid_data), 'hA5);

    // Simultaneous video and CPU requests: video first, CPU 2 clocks later
    bus.vid_addr = 16'h1234;
    bus.vid_req  = 1'b1;
    bus.cpu_addr = 16'hC000;
    bus.cpu_req  = 1'b1;
    tick();
    bus.vid_req = 1'b0;
    chk("colB_vid_addr", 32'(bus.ram_addr), 'h1234);
    chk("colB_waitn",    32'(bus.cpu_wait_n), 0);
    tick();
    chk("colB_ack_b1",   32'(bus.cpu_ack), 0);
    tick();
    chk("colB_valid",    32'(bus.vid_valid), 1);
    chk("colB_cpu_addr", 32'(bus.ram_addr), 'hC000);
    chk("colB_ack_b2",   32'(bus.cpu_ack), 0);
    tick();
    chk("colB_ack_b3",   32'(bus.cpu_ack), 0);
    tick();
    chk("colB_ack_b4",   32'(bus.cpu_ack), 1);
    chk("colB_rdata",    32'(bus.cpu_rdata), 'h5A);
    bus.cpu_req = 1'b0;
    tick();

    // Two video strobes one cycle apart while the CPU access is in flight
    bus.cpu_addr = 16'hC000;
    bus.cpu_req  = 1'b1;
    tick();
    bus.vid_addr = 16'h1234;
    bus.vid_req  = 1'b1;
    tick();
    chk("ovr_before", 32'(bus.vid_overrun), 0);
    bus.vid_addr = 16'h2000;
    tick();
    bus.vid_req = 1'b0;
    chk("ovr_set",     32'(bus.vid_overrun), 1);
    chk("ovr_addr",    32'(bus.ram_addr), 'h2000);
    chk("ovr_cpu_ack", 32'(bus.cpu_ack), 1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("ovr_valid", 32'(bus.vid_valid), 1);
    chk("ovr_data",  32'(bus.vid_data), 'h3C);
    tick();
    chk("ovr_sticky", 32'(bus.vid_overrun), 1);

`ifndef VRAM_WBUF_EN
    // Reset asserted in the CPU_ISSUE cycle of a write aborts it
    bus.cpu_addr  = 16'h3000;
    bus.cpu_wdata = 8'h99;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    tick();
    chk("abort_we_on", 32'(bus.ram_we), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_we_off",  32'(bus.ram_we), 0);
    chk("abort_addr",    32'(bus.ram_addr), 0);
    chk("abort_overrun", 32'(bus.vid_overrun), 0);
    chk("abort_waitn",   32'(bus.cpu_wait_n), 1);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    acks = 0;
    wes  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(bus.cpu_ack);
      wes  += int'(bus.ram_we);
    end
    chk("abort_no_ack", 32'(acks), 0);
    chk("abort_no_we",  32'(wes), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
